uart_decimal_rx: RTL and testbench

- Serial receiver for the USB-UART input (8N1, LSB first). Decodes ASCII decimal entries into a binary number for the 7-segment display path.
- Digits '0'..'9' accumulate. CR or LF commits the accumulated value to a 14-bit output (0..9999), which drives the display multiplexer's displayed_number.
- Input-direction counterpart to the display output path. Replaces the raw rx->tx loopback as the consumer of usb_rx.

---
 rtl/uart_decimal_rx.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_decimal_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_decimal_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_decimal_rx
// Description : Serial receiver for the USB-UART line (8N1, LSB first) that
//               decodes ASCII decimal entries into a 14-bit binary value for
//               the 7-segment display path. Digits accumulate. CR or LF
//               commits the entry.
// Revision    : 1.0 - initial release
//
// Parameters  : CLK_FREQ   - system clock in Hz
//               BAUD       - line rate. Bit period = CLK_FREQ/BAUD clocks.
//               MAX_DIGITS - longest accepted entry. Longer entries are dropped.
// Macro       : UART_PARITY_EN - when defined, one even-parity bit follows the
//               data bits (8E1). A parity mismatch is treated like a bad stop
//               bit.
//
// Ports       : clk          in   system clock
//               rst_n        in   asynchronous active-low reset
//               rx           in   serial line, idle high, asynchronous to clk
//               number       out  last committed value (0..9999)
//               number_valid out  one-cycle pulse when number updates
//               frame_error  out  one-cycle pulse on a framing/parity failure
//               busy         out  high from start detection to stop sample
// ============================================================================
module uart_decimal_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [13:0] number,
  output logic        number_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int c_clks_per_bit = CLK_FREQ / BAUD;
  localparam int c_half_bit     = c_clks_per_bit / 2;
  localparam int c_cnt_w        = ($clog2(c_clks_per_bit) < 1) ? 1 : $clog2(c_clks_per_bit);
  localparam int c_dig_w        = ($clog2(MAX_DIGITS + 1) < 1) ? 1 : $clog2(MAX_DIGITS + 1);

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_bit - 1);
  localparam logic [c_dig_w-1:0] c_max_dig   = c_dig_w'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser and start-edge detection
  // --------------------------------------------------------------------------
  logic       r_rx_meta;
  logic       r_rx_sync;
  logic       r_rx_prev;
  logic [1:0] r_fill;
  logic       w_fall;

  // r_fill counts the clocks since reset release. The synchroniser and edge
  // flops come out of reset at 1, so an edge seen before they have all been
  // refilled from the real line would be false. A line held low at release
  // would otherwise look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'd0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign w_fall = (r_fill == 2'd3) && r_rx_prev && !r_rx_sync;

  // --------------------------------------------------------------------------
  // Bit-level receive FSM
  // --------------------------------------------------------------------------
  state_t             r_state, w_state_next;
  logic [c_cnt_w-1:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]         r_bit_cnt, w_bit_cnt_next;
  logic [7:0]         r_shift, w_shift_next;
  logic               r_par_err, w_par_err_next;
  logic               r_byte_valid, w_byte_valid_next;
  logic               r_frame_error, w_frame_error_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_clk_cnt     <= w_clk_cnt_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_shift       <= w_shift_next;
      r_par_err     <= w_par_err_next;
      r_byte_valid  <= w_byte_valid_next;
      r_frame_error <= w_frame_error_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_clk_cnt_next     = r_clk_cnt + 1'b1;
    w_bit_cnt_next     = r_bit_cnt;
    w_shift_next       = r_shift;
    w_par_err_next     = r_par_err;
    w_byte_valid_next  = 1'b0;
    w_frame_error_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_cnt_next = '0;
        if (w_fall) begin
          w_state_next   = S_START;
          w_bit_cnt_next = '0;
          w_par_err_next = 1'b0;
        end
      end

      // Sample mid start bit. A high line here was a glitch and is dropped
      // silently.
      S_START: begin
        if (r_clk_cnt == c_half_last) begin
          w_clk_cnt_next = '0;
          w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (r_clk_cnt == c_bit_last) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end

`ifdef UART_PARITY_EN
      // Even parity: the data bits and the parity bit XOR to zero.
      S_PARITY: begin
        if (r_clk_cnt == c_bit_last) begin
          w_clk_cnt_next = '0;
          w_par_err_next = r_rx_sync ^ (^r_shift);
          w_state_next   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (r_clk_cnt == c_bit_last) begin
          w_clk_cnt_next = '0;
          w_state_next   = S_IDLE;
          if (r_rx_sync && !r_par_err) begin
            w_byte_valid_next = 1'b1;
          end else begin
            w_frame_error_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Entry decoder: runs on the cycle after the stop sample. r_shift holds the
  // received byte until the next frame's data phase begins.
  // --------------------------------------------------------------------------
  logic [13:0]        r_acc;
  logic [c_dig_w-1:0] r_dig_cnt;
  logic               r_ovf;
  logic [13:0]        r_number;
  logic               r_number_valid;
  logic               w_is_digit;
  logic               w_is_term;
  logic [13:0]        w_acc_next;

  assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
  assign w_is_term  = (r_shift == 8'h0D) || (r_shift == 8'h0A);
  // acc*10 + digit as shift-and-add. With MAX_DIGITS=4 the result fits in 14 bits.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, r_shift[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_dig_cnt      <= '0;
      r_ovf          <= 1'b0;
      r_number       <= '0;
      r_number_valid <= 1'b0;
    end else begin
      r_number_valid <= 1'b0;
      if (r_frame_error) begin
        r_acc     <= '0;
        r_dig_cnt <= '0;
        r_ovf     <= 1'b0;
      end else if (r_byte_valid) begin
        if (w_is_digit) begin
          if (r_dig_cnt < c_max_dig) begin
            r_acc     <= w_acc_next;
            r_dig_cnt <= r_dig_cnt + 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end else begin
          // A terminator on an empty entry (the LF of CRLF) commits nothing.
          if (w_is_term && (r_dig_cnt != '0) && !r_ovf) begin
            r_number       <= r_acc;
            r_number_valid <= 1'b1;
          end
          r_acc     <= '0;
          r_dig_cnt <= '0;
          r_ovf     <= 1'b0;
        end
      end
    end
  end

  assign number       = r_number;
  assign number_valid = r_number_valid;
  assign frame_error  = r_frame_error;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_decimal_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_decimal_rx
// Description : Self-checking bench for uart_decimal_rx. Serial frames are
//               generated at a reduced bit period (20 clocks). Expected
//               commits are queued as entries are sent and matched against
//               number_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_decimal_rx;

  localparam int CLK_FREQ = 2000;
  localparam int BAUD     = 100;
  localparam int CLKS     = CLK_FREQ / BAUD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic [13:0] number;
  logic        number_valid;
  logic        frame_error;
  logic        busy;

  int          n_pass   = 0;
  int          n_total  = 0;
  int          fe_count = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;

  always #5 clk = ~clk;

  uart_decimal_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .MAX_DIGITS(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .number      (number),
    .number_valid(number_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  // Scoreboard: every number_valid pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (number_valid && frame_error) begin
        n_total++;
        $display("FAIL exclusive: number_valid=1 frame_error=1, required never both");
      end
      if (number_valid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL commit: unexpected number_valid, number=%0d, required no pulse", number);
        end else begin
          mon_exp = exp_q.pop_front();
          if (number !== mon_exp) begin
            $display("FAIL commit: number=%0d required %0d", number, mon_exp);
          end else begin
            n_pass++;
          end
        end
      end
      if (frame_error) fe_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
    send_bit((^b) ^ bad_par);
`endif
    send_bit(!bad_stop);
    // A low stop bit leaves no falling edge for the next start; idle first.
    if (bad_stop) begin
      send_bit(1'b1);
      send_bit(1'b1);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 1'b0);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 * CLKS; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (number !== 14'd0) $display("FAIL reset_number: number=%0d required 0", number);
    else n_pass++;
    n_total++;
    if ({number_valid, frame_error, busy} !== 3'b000)
      $display("FAIL reset_flags: valid/ferr/busy=%b required 000", {number_valid, frame_error, busy});
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    bit ok;
    int fe0;
    fe0 = fe_count;
    exp_q.push_back(14'd1234);
    send_str("1234\015");
    drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL basic_drain: timeout, pending=%0d required 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (number !== 14'h4D2) $display("FAIL basic_number: number=%0d required 1234", number);
    else n_pass++;
    n_total++;
    if (fe_count - fe0 !== 0) $display("FAIL basic_ferr: frame_error pulses=%0d required 0", fe_count - fe0);
    else n_pass++;
  endtask

  task automatic test_crlf;
    bit ok;
    exp_q.push_back(14'd7);
    exp_q.push_back(14'd9999);
    send_str("7\015\0129999\012");
    drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL crlf_drain: timeout, pending=%0d required 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (number !== 14'd9999) $display("FAIL crlf_number: number=%0d required 9999", number);
    else n_pass++;
  endtask

  task automatic test_overflow;
    bit ok;
    send_str("12345\015");
    drain(ok);
    n_total++;
    if (number !== 14'd9999) $display("FAIL overflow_hold: number=%0d required 9999", number);
    else n_pass++;
    exp_q.push_back(14'd5);
    send_str("5\015");
    drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL overflow_drain: timeout, pending=%0d required 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (number !== 14'd5) $display("FAIL overflow_next: number=%0d required 5", number);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    exp_q.push_back(14'd42);
    exp_q.push_back(14'd2);
    send_str("0042\0151x2\015");
    drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL b2b_drain: timeout, pending=%0d required 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (number !== 14'd2) $display("FAIL b2b_number: number=%0d required 2", number);
    else n_pass++;
  endtask

  task automatic test_frame_error;
    bit ok;
    int fe0;
    fe0 = fe_count;
    exp_q.push_back(14'd3);
    send_str("12");
    send_byte(8'h35, 1'b1, 1'b0);
    send_str("3\015");
    drain(ok);
    n_total++;
    if (fe_count - fe0 !== 1) $display("FAIL ferr_count: frame_error pulses=%0d required 1", fe_count - fe0);
    else n_pass++;
    n_total++;
    if (number !== 14'd3) $display("FAIL ferr_number: number=%0d required 3", number);
    else n_pass++;
  endtask

  task automatic test_glitch;
    bit ok;
    bit busy_seen;
    int fe0;
    fe0 = fe_count;
    busy_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 3 * CLKS; i++) begin
      @(negedge clk);
      if (i == 3) rx = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    drain(ok);
    n_total++;
    if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen: busy seen=%b required 1", busy_seen);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_clear: busy=%b required 0", busy);
    else n_pass++;
    n_total++;
    if (fe_count - fe0 !== 0) $display("FAIL glitch_ferr: frame_error pulses=%0d required 0", fe_count - fe0);
    else n_pass++;
    n_total++;
    if (number !== 14'd3) $display("FAIL glitch_number: number=%0d required 3", number);
    else n_pass++;
  endtask

  task automatic test_reset_mid_byte;
    bit ok;
    bit busy_seen;
    // Start bit and three low data bits of '8', then reset mid-frame.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL midreset_busy_before: busy=%b required 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({number, number_valid, frame_error, busy} !== 17'd0)
      $display("FAIL midreset_async: number=%0d flags=%b required 0/000",
               number, {number_valid, frame_error, busy});
    else n_pass++;
    // Release while the line is still low: must not be taken as a start.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 3 * CLKS; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    n_total++;
    if (busy_seen !== 1'b0) $display("FAIL midreset_low_release: busy seen=%b required 0", busy_seen);
    else n_pass++;
    @(posedge clk);
    #1;
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.push_back(14'd8);
    send_str("8\015");
    drain(ok);
    n_total++;
    if (number !== 14'd8) $display("FAIL midreset_next: number=%0d required 8", number);
    else n_pass++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    bit ok;
    int fe0;
    fe0 = fe_count;
    send_byte(8'h35, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b1);
    drain(ok);
    n_total++;
    if (fe_count - fe0 !== 1) $display("FAIL parity_ferr: frame_error pulses=%0d required 1", fe_count - fe0);
    else n_pass++;
    n_total++;
    if (number !== 14'd8) $display("FAIL parity_hold: number=%0d required 8", number);
    else n_pass++;
    exp_q.push_back(14'd5);
    send_str("5\015");
    drain(ok);
    n_total++;
    if (number !== 14'd5) $display("FAIL parity_next: number=%0d required 5", number);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_crlf();
    test_overflow();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_byte();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL final_queue: pending commits=%0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
